// File: rtl/spi_master_core_if.sv
// rtl/spi_master_core_if.sv - control and SPI pin bundle for spi_master_core
//
// Purpose: groups the control handshake and SPI pins of spi_master_core.
// Signal names are seen from the core: i_* are driven into the core, o_* are
// driven by the core.
//   i_start    transfer request, sampled only while the core is idle
//   i_tx_data  word to transmit, captured on the accepted start
//   o_rx_data  last received word, updated together with o_done
//   o_busy     high from the accepted start through the done cycle
//   o_done     one-clock pulse when a transfer completes
//   o_cs_b     active-low chip select
//   o_sclk     SPI clock, idles low (mode 0)
//   o_mosi     master out
//   i_miso     slave in, sampled on sclk rising edges
// Modports: master = the core, slave = the front end / pin-side environment.
interface spi_master_core_if #(
  parameter int DATA_W = 8
) ();
  logic              i_start;
  logic [DATA_W-1:0] i_tx_data;
  logic [DATA_W-1:0] o_rx_data;
  logic              o_busy;
  logic              o_done;
  logic              o_cs_b;
  logic              o_sclk;
  logic              o_mosi;
  logic              i_miso;

  modport master (
    input  i_start, i_tx_data, i_miso,
    output o_rx_data, o_busy, o_done, o_cs_b, o_sclk, o_mosi
  );

  modport slave (
    output i_start, i_tx_data, i_miso,
    input  o_rx_data, o_busy, o_done, o_cs_b, o_sclk, o_mosi
  );
endinterface

// File: rtl/spi_master_core.sv
// rtl/spi_master_core.sv - single-word SPI master, mode 0
//
// Purpose: transfers one DATA_W-bit word per accepted start. sclk is derived
// from i_clk with a half-period of CLK_DIV clocks. Frame: SETUP (CLK_DIV clks,
// sclk low) -> XFER (DATA_W sclk periods, starting low) -> HOLD (CLK_DIV clks),
// so cs_b is low for (2*DATA_W+2)*CLK_DIV clocks.
// Ports:
//   i_clk  system clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    spi_master_core_if.master (control handshake and SPI pins)
// Parameters: DATA_W (>=2) bits per word, CLK_DIV (>=1) sclk half-period.
// Build option: define SPI_MASTER_LSB_FIRST_EN to shift LSB first on both
// mosi and miso; default is MSB first. Timing is the same in both builds.
module spi_master_core #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  spi_master_core_if.master bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_HOLD
  } state_t;

  state_t            r_state;
  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_bit;
  logic [DATA_W-1:0] r_tx_sh;
  logic [DATA_W-1:0] r_rx_sh;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_busy;
  logic              r_done;
  logic              r_cs_b;
  logic              r_sclk;
  logic              r_mosi;

  logic              w_div_wrap;
  logic              w_tx_first;
  logic              w_tx_next;
  logic [DATA_W-1:0] w_tx_shifted;
  logic [DATA_W-1:0] w_rx_shifted;

  assign w_div_wrap = (r_div == DIV_W'(CLK_DIV - 1));

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign w_tx_first   = bus.i_tx_data[0];
  assign w_tx_next    = r_tx_sh[1];
  assign w_tx_shifted = {1'b0, r_tx_sh[DATA_W-1:1]};
  assign w_rx_shifted = {bus.i_miso, r_rx_sh[DATA_W-1:1]};
`else
  assign w_tx_first   = bus.i_tx_data[DATA_W-1];
  assign w_tx_next    = r_tx_sh[DATA_W-2];
  assign w_tx_shifted = {r_tx_sh[DATA_W-2:0], 1'b0};
  assign w_rx_shifted = {r_rx_sh[DATA_W-2:0], bus.i_miso};
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit     <= '0;
      r_tx_sh   <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cs_b    <= 1'b1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The first idle cycle is also the done cycle; busy only drops
          // here if no new word is accepted on this edge.
          r_busy <= 1'b0;
          r_div  <= '0;
          r_bit  <= '0;
          if (bus.i_start) begin
            r_tx_sh <= bus.i_tx_data;
            r_rx_sh <= '0;
            r_cs_b  <= 1'b0;
            r_busy  <= 1'b1;
            r_mosi  <= w_tx_first;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_div_wrap) begin
            r_div   <= '0;
            r_state <= S_XFER;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_XFER: begin
          if (w_div_wrap) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            if (!r_sclk) begin
              // Rising edge: miso has been stable since the previous fall.
              r_rx_sh <= w_rx_shifted;
            end else begin
              // Falling edge: count it; the last one leaves mosi untouched.
              r_bit <= r_bit + BIT_W'(1);
              if (r_bit == BIT_W'(DATA_W - 1)) begin
                r_state <= S_HOLD;
              end else begin
                r_tx_sh <= w_tx_shifted;
                r_mosi  <= w_tx_next;
              end
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_HOLD: begin
          if (w_div_wrap) begin
            r_div     <= '0;
            r_cs_b    <= 1'b1;
            r_mosi    <= 1'b0;
            r_rx_data <= r_rx_sh;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_rx_data = r_rx_data;
  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
  assign bus.o_cs_b    = r_cs_b;
  assign bus.o_sclk    = r_sclk;
  assign bus.o_mosi    = r_mosi;

endmodule

// File: tb/tb_spi_master_core.sv
// tb/tb_spi_master_core.sv - scoreboard bench for spi_master_core
`timescale 1ns/1ps
module tb_spi_master_core;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int W2   = 16;
  localparam int D2   = 1;
  localparam int LAT  = (2 * W + 2) * D;
  localparam int LAT2 = (2 * W2 + 2) * D2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Position in the word of the k-th bit on the wire.
  function automatic int bitpos(input int k, input int w);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return k;
`else
    return w - 1 - k;
`endif
  endfunction

  spi_master_core_if #(.DATA_W(W))  ifa ();
  spi_master_core_if #(.DATA_W(W2)) ifb ();

  spi_master_core #(.DATA_W(W), .CLK_DIV(D)) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifa)
  );

  spi_master_core #(.DATA_W(W2), .CLK_DIV(D2)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifb)
  );

  // Behavioural slave on A: first bit valid at cs_b fall, shifts on sclk fall,
  // captures mosi on sclk rise. Loopback mode bypasses its miso.
  logic [W-1:0] slv_word = '0;
  logic [W-1:0] slv_cap  = '0;
  logic         slv_miso = 1'b0;
  int           slv_k    = 0;
  logic         loop_a   = 1'b1;

  assign ifa.i_miso = loop_a ? ifa.o_mosi : slv_miso;
  assign ifb.i_miso = ifb.o_mosi;

  always @(negedge ifa.o_cs_b) begin
    slv_k    = 0;
    slv_cap  = '0;
    slv_miso = slv_word[bitpos(0, W)];
  end
  always @(posedge ifa.o_sclk) begin
    if (!ifa.o_cs_b && slv_k < W) slv_cap[bitpos(slv_k, W)] = ifa.o_mosi;
  end
  always @(negedge ifa.o_sclk) begin
    if (!ifa.o_cs_b) begin
      slv_k++;
      if (slv_k < W) slv_miso = slv_word[bitpos(slv_k, W)];
    end
  end

  typedef struct {
    logic [W2-1:0] rx;
    logic [W2-1:0] tx;
    int            acc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   done_a[$];
  int   done_b_cnt = 0;

  // Monitor A
  exp_t ea;
  int   cs_lo   = 0;
  int   rises   = 0;
  int   busy_lo = 0;
  logic sclk_d  = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      cs_lo = 0; rises = 0; busy_lo = 0; sclk_d = 1'b0;
    end else begin
      if (!ifa.o_cs_b) cs_lo++;
      if (!ifa.o_cs_b && !ifa.o_busy) busy_lo++;
      if (ifa.o_sclk && !sclk_d) rises++;
      sclk_d = ifa.o_sclk;
      if (ifa.o_done) begin
        if (q_a.size() == 0) begin
          chk("a_unexpected_done", 32'(ifa.o_done), 32'd0);
        end else begin
          ea = q_a.pop_front();
          chk("a_rx_data", 32'(ifa.o_rx_data), 32'(ea.rx[W-1:0]));
          chk("a_slave_cap", 32'(slv_cap), 32'(ea.tx[W-1:0]));
          chk("a_latency", 32'(cyc - 1 - ea.acc), 32'(LAT));
          chk("a_cs_low", 32'(cs_lo), 32'(LAT));
          chk("a_sclk_rises", 32'(rises), 32'(W));
          chk("a_busy_gap", 32'(busy_lo), 32'd0);
          chk("a_busy_in_done", 32'(ifa.o_busy), 32'd1);
          chk("a_cs_b_at_done", 32'(ifa.o_cs_b), 32'd1);
        end
        done_a.push_back(cyc);
        cs_lo = 0; rises = 0; busy_lo = 0;
      end
    end
  end

  // Monitor B (loopback, collects mosi at each sclk rise)
  exp_t eb;
  logic mosi_b[$];
  logic sclkb_d = 1'b0;
  logic [W2-1:0] wb;
  always @(negedge clk) begin
    if (rst) begin
      mosi_b.delete(); sclkb_d = 1'b0;
    end else begin
      if (ifb.o_sclk && !sclkb_d) mosi_b.push_back(ifb.o_mosi);
      sclkb_d = ifb.o_sclk;
      if (ifb.o_done) begin
        done_b_cnt++;
        if (q_b.size() == 0) begin
          chk("b_unexpected_done", 32'(ifb.o_done), 32'd0);
        end else begin
          eb = q_b.pop_front();
          wb = '0;
          for (int k = 0; k < mosi_b.size() && k < W2; k++) wb[bitpos(k, W2)] = mosi_b[k];
          chk("b_rx_data", 32'(ifb.o_rx_data), 32'(eb.rx));
          chk("b_mosi_word", 32'(wb), 32'(eb.tx));
          chk("b_mosi_bits", 32'(mosi_b.size()), 32'(W2));
          chk("b_latency", 32'(cyc - 1 - eb.acc), 32'(LAT2));
        end
        mosi_b.delete();
      end
    end
  end

  task automatic start_a(input logic [W-1:0] tx, input logic [W-1:0] sw,
                         input logic lp, output int acc);
    exp_t e;
    @(negedge clk);
    loop_a        = lp;
    slv_word      = sw;
    ifa.i_tx_data = tx;
    ifa.i_start   = 1'b1;
    @(posedge clk);
    acc   = cyc;
    e.tx  = W2'(tx);
    e.rx  = lp ? W2'(tx) : W2'(sw);
    e.acc = acc;
    q_a.push_back(e);
    @(negedge clk);
    ifa.i_start   = 1'b0;
    ifa.i_tx_data = W'($urandom);
  endtask

  task automatic start_b(input logic [W2-1:0] tx, output int acc);
    exp_t e;
    @(negedge clk);
    ifb.i_tx_data = tx;
    ifb.i_start   = 1'b1;
    @(posedge clk);
    acc   = cyc;
    e.tx  = tx;
    e.rx  = tx;
    e.acc = acc;
    q_b.push_back(e);
    @(negedge clk);
    ifb.i_start   = 1'b0;
    ifb.i_tx_data = W2'($urandom);
  endtask

  task automatic wait_idle_a();
    int n = 0;
    @(negedge clk);
    while ((ifa.o_busy || ifa.o_done || q_a.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail("a_idle_wait");
  endtask

  task automatic wait_idle_b();
    int n = 0;
    @(negedge clk);
    while ((ifb.o_busy || ifb.o_done || q_b.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail("b_idle_wait");
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc1, nd, gap;
    ifa.i_start = 1'b0; ifa.i_tx_data = '0;
    ifb.i_start = 1'b0; ifb.i_tx_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cs_b", 32'(ifa.o_cs_b), 32'd1);
    chk("rst_sclk", 32'(ifa.o_sclk), 32'd0);
    chk("rst_mosi", 32'(ifa.o_mosi), 32'd0);
    chk("rst_busy", 32'(ifa.o_busy), 32'd0);
    chk("rst_done", 32'(ifa.o_done), 32'd0);
    chk("rst_rx",   32'(ifa.o_rx_data), 32'd0);
    chk("rst_b_cs_b", 32'(ifb.o_cs_b), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Loopback A5, checking the first bit on the wire right after accept
    start_a(8'hA5, 8'h00, 1'b1, acc);
    chk("a5_first_mosi", 32'(ifa.o_mosi), 32'(1'b1));
    chk("a5_busy", 32'(ifa.o_busy), 32'd1);
    wait_idle_a();

    // Slave model returns 3C while master sends C3
    start_a(8'hC3, 8'h3C, 1'b0, acc);
    wait_idle_a();

    // Start while busy: second request at clk 20 must be ignored
    nd = done_a.size();
    start_a(8'h12, W'($urandom), 1'b0, acc);
    wait_cyc(acc + 20);
    ifa.i_tx_data = 8'hFF;
    ifa.i_start   = 1'b1;
    @(negedge clk);
    ifa.i_start   = 1'b0;
    wait_idle_a();
    repeat (5) @(negedge clk);
    chk("busy_start_one_done", 32'(done_a.size() - nd), 32'd1);

    // Back-to-back with start held high
    begin
      exp_t e;
      @(negedge clk);
      loop_a = 1'b1;
      ifa.i_tx_data = 8'h01;
      ifa.i_start   = 1'b1;
      @(posedge clk);
      acc1 = cyc;
      e.tx = 16'h0001; e.rx = 16'h0001; e.acc = acc1;
      q_a.push_back(e);
      e.acc = acc1 + LAT + 1;
      q_a.push_back(e);
      nd = done_a.size();
      wait_cyc(acc1 + LAT + 2);
      ifa.i_start = 1'b0;
      wait_idle_a();
      chk("b2b_done_count", 32'(done_a.size() - nd), 32'd2);
      if (done_a.size() - nd == 2) begin
        gap = done_a[done_a.size()-1] - done_a[done_a.size()-2];
        chk("b2b_done_spacing", 32'(gap), 32'(LAT + 1));
      end
    end

    // Reset mid-transfer
    start_a(W'($urandom), W'($urandom), 1'b1, acc);
    wait_cyc(acc + 30);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cs_b", 32'(ifa.o_cs_b), 32'd1);
    chk("mid_rst_sclk", 32'(ifa.o_sclk), 32'd0);
    chk("mid_rst_mosi", 32'(ifa.o_mosi), 32'd0);
    chk("mid_rst_busy", 32'(ifa.o_busy), 32'd0);
    chk("mid_rst_done", 32'(ifa.o_done), 32'd0);
    chk("mid_rst_rx",   32'(ifa.o_rx_data), 32'd0);
    q_a.delete();
    nd = done_a.size();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_a.size() - nd), 32'd0);
    start_a(8'h5A, 8'h00, 1'b1, acc);
    wait_idle_a();

    // Randomised words, modes, gaps and ignored starts
    for (int i = 0; i < 20; i++) begin
      start_a(W'($urandom), W'($urandom), 1'($urandom), acc);
      if ($urandom_range(0, 1) == 1) begin
        wait_cyc(acc + 2 + int'($urandom_range(0, 55)));
        ifa.i_tx_data = W'($urandom);
        ifa.i_start   = 1'b1;
        @(negedge clk);
        ifa.i_start   = 1'b0;
      end
      wait_idle_a();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Corner: 16-bit word, divide-by-1, loopback
    start_b(16'h8001, acc);
    chk("b_first_mosi", 32'(ifb.o_mosi), 32'd1);
    wait_idle_b();
    for (int i = 0; i < 8; i++) begin
      start_b(W2'($urandom), acc);
      wait_idle_b();
    end
    chk("b_done_count", 32'(done_b_cnt), 32'd9);

    repeat (4) @(negedge clk);
    chk("a_queue_empty", 32'(q_a.size()), 32'd0);
    chk("b_queue_empty", 32'(q_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
